// File: rtl/rtc_bus_arbiter_if.sv
// Bus bundle between the RTC bus arbiter, the state-machine layer and the pad logic.
// The slave side is the arbiter; the master side is everything around it.
interface rtc_bus_arbiter_if;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       ChipSelect;
    logic       Read;
    logic       Write;
    logic       AoD;
    logic       busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ad_in,
        output rd_done, rd_data, wr_done, ad_out, ad_oe,
               ChipSelect, Read, Write, AoD, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ad_in,
        input  rd_done, rd_data, wr_done, ad_out, ad_oe,
               ChipSelect, Read, Write, AoD, busy
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Sequences address/data transfers on the multiplexed RTC bus and alternates
// between a read (display refresh) and a write (edit/program) requester.
//
// state   | meaning
// IDLE    | bus released, arbitrating between rd_req and wr_req
// ADDR    | address strobe (Write low, AoD=0) for T_PULSE clocks
// AHOLD   | address hold; reads release the bus here for turnaround
// DATA    | data strobe (Write or Read low, AoD=1) for T_PULSE clocks
// DHOLD   | data hold for T_HOLD clocks
// GAP     | bus released, recovery for T_GAP clocks
// DONE    | one-cycle done pulse for the served channel
module rtc_bus_arbiter #(
    parameter int T_PULSE = 10,
    parameter int T_HOLD  = 4,
    parameter int T_GAP   = 4
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_arbiter_if.slave   bus
);
    localparam logic [7:0] L_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] L_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] L_GAP   = 8'(T_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AHOLD, S_DATA, S_DHOLD, S_GAP, S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_is_wr;
    logic       r_last_wr;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_rd_data;

    state_t     w_next;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_tc;
    logic       w_grant;
    logic       w_grant_wr;
    logic       w_cs, w_rd, w_wr, w_aod, w_oe, w_rd_done, w_wr_done;
    logic [7:0] w_ad_out;

    // On a tie the channel that was not served last wins; reset leaves READ as last.
    assign w_grant    = bus.rd_req | bus.wr_req;
    assign w_grant_wr = bus.wr_req & (~bus.rd_req | ~r_last_wr);
    assign w_tc       = (r_cnt == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_is_wr   <= 1'b0;
            r_last_wr <= 1'b0;
            r_addr    <= 8'd0;
            r_data    <= 8'd0;
            r_rd_data <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_cnt <= w_load_val;
            else if (!w_tc)
                r_cnt <= r_cnt - 8'd1;
            if (r_state == S_IDLE && w_grant) begin
                r_is_wr   <= w_grant_wr;
                r_last_wr <= w_grant_wr;
                r_addr    <= w_grant_wr ? bus.wr_addr : bus.rd_addr;
                if (w_grant_wr)
                    r_data <= bus.wr_data;
            end
            if (r_state == S_DATA && w_tc && !r_is_wr)
                r_rd_data <= bus.ad_in;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = 8'd0;
        unique case (r_state)
            S_IDLE:  if (w_grant) begin w_next = S_ADDR;  w_load = 1'b1; w_load_val = L_PULSE; end
            S_ADDR:  if (w_tc)    begin w_next = S_AHOLD; w_load = 1'b1; w_load_val = L_HOLD;  end
            S_AHOLD: if (w_tc)    begin w_next = S_DATA;  w_load = 1'b1; w_load_val = L_PULSE; end
            S_DATA:  if (w_tc)    begin w_next = S_DHOLD; w_load = 1'b1; w_load_val = L_HOLD;  end
            S_DHOLD: if (w_tc)    begin w_next = S_GAP;   w_load = 1'b1; w_load_val = L_GAP;   end
            S_GAP:   if (w_tc)    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode from the state register only, so async reset releases the bus at once.
    always_comb begin
        w_cs      = 1'b1;
        w_rd      = 1'b1;
        w_wr      = 1'b1;
        w_aod     = 1'b1;
        w_oe      = 1'b0;
        w_ad_out  = 8'd0;
        w_rd_done = 1'b0;
        w_wr_done = 1'b0;
        unique case (r_state)
            S_ADDR: begin
                w_cs     = 1'b0;
                w_wr     = 1'b0;
                w_aod    = 1'b0;
                w_oe     = 1'b1;
                w_ad_out = r_addr;
            end
            S_AHOLD: begin
                w_aod    = 1'b0;
                w_oe     = r_is_wr;
                w_ad_out = r_addr;
            end
            S_DATA: begin
                w_cs = 1'b0;
                if (r_is_wr) begin
                    w_wr     = 1'b0;
                    w_oe     = 1'b1;
                    w_ad_out = r_data;
                end else begin
                    w_rd = 1'b0;
                end
            end
            S_DHOLD: begin
                if (r_is_wr) begin
                    w_oe     = 1'b1;
                    w_ad_out = r_data;
                end
            end
            S_DONE: begin
                w_rd_done = ~r_is_wr;
                w_wr_done = r_is_wr;
            end
            default: ;
        endcase
    end

    assign bus.ChipSelect = w_cs;
    assign bus.Read       = w_rd;
    assign bus.Write      = w_wr;
    assign bus.AoD        = w_aod;
    assign bus.ad_oe      = w_oe;
    assign bus.ad_out     = w_ad_out;
    assign bus.rd_done    = w_rd_done;
    assign bus.wr_done    = w_wr_done;
    assign bus.rd_data    = r_rd_data;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: default timing instance plus a 1/1/1 timing
// instance, scoreboard of expected transfers checked cycle by cycle.
module tb_rtc_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rtc_bus_arbiter_if if0 ();
    rtc_bus_arbiter_if if1 ();

    rtc_bus_arbiter dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    rtc_bus_arbiter #(.T_PULSE(1), .T_HOLD(1), .T_GAP(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    // RTC bus model: drives the read value only while the read strobe is low.
    logic [7:0] bus_val0, bus_val1;
    assign if0.ad_in = (if0.Read == 1'b0) ? bus_val0 : 8'hEE;
    assign if1.ad_in = (if1.Read == 1'b0) ? bus_val1 : 8'hEE;

    int sel;
    logic m_cs, m_rd, m_wr, m_aod, m_oe, m_busy, m_rd_done, m_wr_done;
    logic [7:0] m_ad_out, m_rd_data;
    assign m_cs      = (sel == 0) ? if0.ChipSelect : if1.ChipSelect;
    assign m_rd      = (sel == 0) ? if0.Read       : if1.Read;
    assign m_wr      = (sel == 0) ? if0.Write      : if1.Write;
    assign m_aod     = (sel == 0) ? if0.AoD        : if1.AoD;
    assign m_oe      = (sel == 0) ? if0.ad_oe      : if1.ad_oe;
    assign m_busy    = (sel == 0) ? if0.busy       : if1.busy;
    assign m_rd_done = (sel == 0) ? if0.rd_done    : if1.rd_done;
    assign m_wr_done = (sel == 0) ? if0.wr_done    : if1.wr_done;
    assign m_ad_out  = (sel == 0) ? if0.ad_out     : if1.ad_out;
    assign m_rd_data = (sel == 0) ? if0.rd_data    : if1.rd_data;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or the value the bus model returns for a read
    } item_t;
    item_t sb[$];

    logic [7:0] exp_rd [2];
    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [7:0] d);
        if (sel == 0) begin if0.wr_addr = a; if0.wr_data = d; if0.wr_req = 1'b1; end
        else          begin if1.wr_addr = a; if1.wr_data = d; if1.wr_req = 1'b1; end
    endtask

    task automatic set_rd(input logic [7:0] a);
        if (sel == 0) begin if0.rd_addr = a; if0.rd_req = 1'b1; end
        else          begin if1.rd_addr = a; if1.rd_req = 1'b1; end
    endtask

    task automatic drop_req(input bit is_wr);
        if (sel == 0) begin if (is_wr) if0.wr_req = 1'b0; else if0.rd_req = 1'b0; end
        else          begin if (is_wr) if1.wr_req = 1'b0; else if1.rd_req = 1'b0; end
    endtask

    // Disturb the request-side address/data after the grant; a second call restores them.
    task automatic flip_inputs();
        if (sel == 0) begin
            if0.wr_addr ^= 8'hFF; if0.wr_data ^= 8'hFF; if0.rd_addr ^= 8'hFF;
        end else begin
            if1.wr_addr ^= 8'hFF; if1.wr_data ^= 8'hFF; if1.rd_addr ^= 8'hFF;
        end
    endtask

    // Waits for the next transfer, pops its expectation and checks every cycle up to DONE.
    // Returns on the negedge inside the DONE cycle.
    task automatic watch(input int p, input int h, input int g, input bit keep);
        item_t it;
        int n, last;
        logic [4:0] ev;
        logic [7:0] eo;
        bit cmp_out, is_done;
        string ph;
        @(negedge clk);
        n = 0;
        while (!m_busy && n < 200) begin @(negedge clk); n++; end
        chk("start_timeout", n >= 200, 0);
        if (n >= 200) return;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        it = sb.pop_front();
        if (!it.is_wr) begin if (sel == 0) bus_val0 = it.data; else bus_val1 = it.data; end
        last = 2 * p + 2 * h + g + 1;
        for (int k = 1; k <= last; k++) begin
            cmp_out = 1'b0;
            is_done = 1'b0;
            eo = 8'h00;
            if (k <= p) begin
                ph = "ADDR"; ev = 5'b01001; eo = it.addr; cmp_out = 1'b1;
            end else if (k <= p + h) begin
                ph = "AHOLD"; ev = {4'b1110, it.is_wr}; eo = it.addr; cmp_out = 1'b1;
            end else if (k <= 2 * p + h) begin
                ph = "DATA";
                if (it.is_wr) begin ev = 5'b01011; eo = it.data; cmp_out = 1'b1; end
                else ev = 5'b00110;
            end else if (k <= 2 * p + 2 * h) begin
                ph = "DHOLD"; ev = {4'b1111, it.is_wr}; eo = it.data; cmp_out = it.is_wr;
            end else if (k <= 2 * p + 2 * h + g) begin
                ph = "GAP"; ev = 5'b11110;
            end else begin
                ph = "DONE"; ev = 5'b11100; is_done = 1'b1;
            end
            if (is_done)
                chk($sformatf("%s_k%0d_strobes", ph, k), {m_cs, m_rd, m_wr}, ev[4:2]);
            else
                chk($sformatf("%s_k%0d_cs_rd_wr_aod_oe", ph, k), {m_cs, m_rd, m_wr, m_aod, m_oe}, ev);
            if (cmp_out)
                chk($sformatf("%s_k%0d_ad_out", ph, k), m_ad_out, eo);
            chk($sformatf("%s_k%0d_busy", ph, k), m_busy, 1);
            if (is_done) begin
                chk("wr_done_pulse", m_wr_done, it.is_wr);
                chk("rd_done_pulse", m_rd_done, !it.is_wr);
                if (!it.is_wr) exp_rd[sel] = it.data;
                chk("rd_data_at_done", m_rd_data, exp_rd[sel]);
                flip_inputs();
                if (!keep) drop_req(it.is_wr);
            end else begin
                chk($sformatf("%s_k%0d_no_done", ph, k), {m_wr_done, m_rd_done}, 2'b00);
                if (k == 1) flip_inputs();
                @(negedge clk);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sel = 0;
        reset = 1'b0;
        bus_val0 = 8'h00; bus_val1 = 8'h00;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        if0.rd_req = 1'b0; if0.wr_req = 1'b0; if0.rd_addr = 8'h00; if0.wr_addr = 8'h00; if0.wr_data = 8'h00;
        if1.rd_req = 1'b0; if1.wr_req = 1'b0; if1.rd_addr = 8'h00; if1.wr_addr = 8'h00; if1.wr_data = 8'h00;
        #1;
        // Reset values, before any clock edge
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("reset_ctrl", {m_cs, m_rd, m_wr, m_aod, m_oe, m_busy, m_rd_done, m_wr_done}, 8'b11110000);
            chk("reset_ad_out", m_ad_out, 8'h00);
            chk("reset_rd_data", m_rd_data, 8'h00);
        end
        sel = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single write, default timing
        sb.push_back('{1'b1, 8'h21, 8'h59});
        set_wr(8'h21, 8'h59);
        watch(10, 4, 4, 1'b0);

        // Single read, bus returns 0x37
        sb.push_back('{1'b0, 8'h22, 8'h37});
        set_rd(8'h22);
        watch(10, 4, 4, 1'b0);
        repeat (3) @(negedge clk);
        chk("rd_data_held", m_rd_data, 8'h37);
        chk("idle_after_read", m_busy, 0);

        // Tie right after reset: write first, then read
        pulse_reset();
        sb.push_back('{1'b1, 8'h30, 8'hA1});
        sb.push_back('{1'b0, 8'h31, 8'h5C});
        set_wr(8'h30, 8'hA1);
        set_rd(8'h31);
        watch(10, 4, 4, 1'b0);
        watch(10, 4, 4, 1'b0);

        // Both held high continuously: wr, rd, wr, rd
        pulse_reset();
        sb.push_back('{1'b1, 8'h40, 8'h11});
        sb.push_back('{1'b0, 8'h41, 8'h66});
        sb.push_back('{1'b1, 8'h40, 8'h11});
        sb.push_back('{1'b0, 8'h41, 8'h77});
        set_wr(8'h40, 8'h11);
        set_rd(8'h41);
        watch(10, 4, 4, 1'b1);
        watch(10, 4, 4, 1'b1);
        watch(10, 4, 4, 1'b1);
        watch(10, 4, 4, 1'b1);
        drop_req(1'b1);
        drop_req(1'b0);
        repeat (3) @(negedge clk);
        chk("idle_after_alternation", m_busy, 0);
        chk("sb_drained", sb.size(), 0);

        // Reset during the DATA phase of a write
        set_wr(8'h55, 8'hAA);
        n = 0;
        @(negedge clk);
        while (!(m_wr == 1'b0 && m_aod == 1'b1) && n < 100) begin @(negedge clk); n++; end
        chk("data_phase_timeout", n >= 100, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_cs_wr_oe_busy", {m_cs, m_wr, m_oe, m_busy}, 4'b1100);
        drop_req(1'b1);
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle_k%0d", k), {m_busy, m_wr_done, m_rd_done}, 3'b000);
        end
        chk("post_reset_rd_data", m_rd_data, 8'h00);

        // Minimum timing instance
        sel = 1;
        #1;
        sb.push_back('{1'b1, 8'h12, 8'h34});
        set_wr(8'h12, 8'h34);
        watch(1, 1, 1, 1'b0);
        sb.push_back('{1'b0, 8'h13, 8'hC3});
        set_rd(8'h13);
        watch(1, 1, 1, 1'b0);
        repeat (2) @(negedge clk);
        chk("sweep_rd_data_held", m_rd_data, 8'hC3);
        chk("sweep_idle", m_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
